// File: rtl/replay_demux.sv
// ============================================================================
// Module  : replay_demux
// Purpose : Captures one gamma window of serial spike slots into a ping-pong
//           bank and replays it as NUM_INPUTS parallel lines one window later.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module replay_demux #(
  parameter int NUM_INPUTS = 2,
  parameter int STEPS      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  grst,
  input  logic                  data_in,
  output logic [NUM_INPUTS-1:0] data_out,
  output logic                  frame_valid,
  output logic                  overrun
);

  localparam int SLOTS  = NUM_INPUTS * STEPS;
  localparam int CH_W   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [CH_W-1:0]   c_last_ch   = CH_W'(NUM_INPUTS - 1);
  localparam logic [STEP_W-1:0] c_last_step = STEP_W'(STEPS - 1);
  localparam logic [CH_W-1:0]   c_second_ch = CH_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_grst_d;
  logic w_b_edge;
  logic w_active;

  // Two banks, each indexed [step][channel]; serial slot k lands at
  // [k / NUM_INPUTS][k % NUM_INPUTS].
  logic [STEPS-1:0][NUM_INPUTS-1:0] r_bank [2];

  logic              r_wr_bank;
  logic              w_wr_nxt;
  logic [CH_W-1:0]   r_wr_ch;
  logic [STEP_W-1:0] r_wr_step;
  logic              r_wr_full;

  logic              r_rd_bank;
  logic [CH_W-1:0]   r_rd_ch;
  logic [STEP_W-1:0] r_rd_step;
  logic              r_rd_done;

  logic [NUM_INPUTS-1:0] r_data_out;
  logic                  r_frame_valid;
  logic                  r_overrun;

  assign w_b_edge    = grst & ~r_grst_d;
  assign w_active    = (r_state != S_IDLE);
  assign w_wr_nxt    = ~r_wr_bank;

  assign data_out    = r_data_out;
  assign frame_valid = r_frame_valid;
  assign overrun     = r_overrun;

  // grst_d resets high so a grst already asserted at release is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grst_d <= 1'b1;
      r_state  <= S_IDLE;
    end else begin
      r_grst_d <= grst;
      r_state  <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_b_edge) w_state_nxt = S_PRIME;
      S_PRIME: if (w_b_edge) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture side: the bank entered at a boundary is wiped so a short window
  // leaves its uncaptured slots at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bank[0] <= '0;
      r_bank[1] <= '0;
      r_wr_bank <= 1'b0;
      r_wr_ch   <= '0;
      r_wr_step <= '0;
      r_wr_full <= 1'b1;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_b_edge) begin
        r_wr_bank           <= w_wr_nxt;
        r_bank[w_wr_nxt]    <= '0;
        r_bank[w_wr_nxt][0] <= NUM_INPUTS'(data_in);
        r_wr_ch             <= c_second_ch;
        r_wr_step           <= '0;
        r_wr_full           <= 1'b0;
      end else if (w_active) begin
        if (!r_wr_full) begin
          r_bank[r_wr_bank][r_wr_step][r_wr_ch] <= data_in;
          if (r_wr_ch == c_last_ch) begin
            r_wr_ch <= '0;
            if (r_wr_step == c_last_step) begin
              r_wr_full <= 1'b1;
            end else begin
              r_wr_step <= r_wr_step + 1'b1;
            end
          end else begin
            r_wr_ch <= r_wr_ch + 1'b1;
          end
        end else begin
          r_overrun <= data_in;
        end
      end
    end
  end

  // Replay side: at a boundary the just-completed write bank is read directly
  // for step 0, so the replay starts on the boundary edge itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_bank     <= 1'b0;
      r_rd_ch       <= '0;
      r_rd_step     <= '0;
      r_rd_done     <= 1'b1;
      r_data_out    <= '0;
      r_frame_valid <= 1'b0;
    end else if (w_b_edge && w_active) begin
      r_rd_bank     <= r_wr_bank;
      r_data_out    <= r_bank[r_wr_bank][0];
      r_frame_valid <= 1'b1;
      r_rd_ch       <= c_second_ch;
      r_rd_step     <= '0;
      r_rd_done     <= 1'b0;
    end else if ((r_state == S_RUN) && !r_rd_done) begin
      r_data_out    <= r_bank[r_rd_bank][r_rd_step];
      r_frame_valid <= 1'b1;
      if (r_rd_ch == c_last_ch) begin
        r_rd_ch <= '0;
        if (r_rd_step == c_last_step) begin
          r_rd_done <= 1'b1;
        end else begin
          r_rd_step <= r_rd_step + 1'b1;
        end
      end else begin
        r_rd_ch <= r_rd_ch + 1'b1;
      end
    end else begin
      r_data_out    <= '0;
      r_frame_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_replay_demux.sv
// ============================================================================
// Module  : tb_replay_demux
// Purpose : Self-checking bench for replay_demux against a window-level model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_replay_demux;

  localparam int N     = 2;
  localparam int STEPS = 8;
  localparam int SLOTS = N * STEPS;

  logic         clk     = 1'b0;
  logic         rst     = 1'b1;
  logic         grst    = 1'b0;
  logic         data_in = 1'b0;
  logic [N-1:0] data_out;
  logic         frame_valid;
  logic         overrun;

  replay_demux #(.NUM_INPUTS(N), .STEPS(STEPS)) dut (
    .clk        (clk),
    .rst        (rst),
    .grst       (grst),
    .data_in    (data_in),
    .data_out   (data_out),
    .frame_valid(frame_valid),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Window-level model: mode 0 = no window seen, 1 = first window capturing,
  // 2 = replaying previous window while capturing the current one.
  bit           m_gd;
  int           m_mode;
  bit           m_cap [SLOTS];
  bit           m_rep [SLOTS];
  int           m_wcnt;
  int           m_rpos;
  logic [N-1:0] m_out;
  logic         m_fv;
  logic         m_ovr;

  task automatic model_reset();
    m_gd   = 1'b1;
    m_mode = 0;
    for (int k = 0; k < SLOTS; k++) begin
      m_cap[k] = 1'b0;
      m_rep[k] = 1'b0;
    end
    m_wcnt = SLOTS;
    m_rpos = SLOTS;
    m_out  = '0;
    m_fv   = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic model_edge(input bit g, input bit d);
    bit b;
    b     = g && !m_gd;
    m_gd  = g;
    m_ovr = 1'b0;
    if (b) begin
      if (m_mode != 0) begin
        m_rep  = m_cap;
        m_rpos = 0;
      end
      for (int k = 0; k < SLOTS; k++) m_cap[k] = 1'b0;
      m_cap[0] = d;
      m_wcnt   = 1;
      m_mode   = (m_mode == 0) ? 1 : 2;
    end else if (m_mode != 0) begin
      if (m_wcnt < SLOTS) begin
        m_cap[m_wcnt] = d;
        m_wcnt++;
      end else if (d) begin
        m_ovr = 1'b1;
      end
    end
    if (m_mode == 2 && m_rpos < SLOTS) begin
      for (int ch = 0; ch < N; ch++) m_out[ch] = m_rep[(m_rpos / N) * N + ch];
      m_fv = 1'b1;
      m_rpos++;
    end else begin
      m_out = '0;
      m_fv  = 1'b0;
    end
  endtask

  // Drive one slot at the falling edge, let the DUT clock it, return at the
  // next falling edge with the model holding the expected outputs.
  task automatic cyc(input bit g, input bit d);
    grst    = g;
    data_in = d;
    model_edge(g, d);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; grst = 1'b0; data_in = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (data_out !== '0) begin
      n_fail++; $display("FAIL reset_data_out: got %b want 00", data_out);
    end
    n_tests++;
    if (frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_frame_valid: got %b want 0", frame_valid);
    end
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun);
    end
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    n_tests++;
    if ({data_out, frame_valid, overrun} !== {m_out, m_fv, m_ovr}) begin
      n_fail++;
      $display("FAIL reset_idle: out=%b fv=%b ovr=%b want out=%b fv=%b ovr=%b",
               data_out, frame_valid, overrun, m_out, m_fv, m_ovr);
    end
  endtask

  task automatic test_single_spike();
    for (int w = 0; w < 2; w++) begin
      for (int j = 0; j < SLOTS; j++) begin
        cyc(j == 0, (w == 0) && (j == 5));
        n_tests++;
        if ({data_out, frame_valid, overrun} !== {m_out, m_fv, m_ovr}) begin
          n_fail++;
          $display("FAIL single_spike w%0d j%0d: out=%b fv=%b ovr=%b want out=%b fv=%b ovr=%b",
                   w, j, data_out, frame_valid, overrun, m_out, m_fv, m_ovr);
        end
        if (w == 1) begin
          n_tests++;
          if (data_out !== ((j == 4 || j == 5) ? 2'b10 : 2'b00) || frame_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_spike_replay j%0d: out=%b fv=%b want out=%b fv=1",
                     j, data_out, frame_valid, (j == 4 || j == 5) ? 2'b10 : 2'b00);
          end
        end
      end
    end
  endtask

  task automatic test_alternating();
    for (int w = 0; w < 2; w++) begin
      for (int j = 0; j < SLOTS; j++) begin
        cyc(j == 0, (w == 0) && (j % 2 == 0));
        n_tests++;
        if ({data_out, frame_valid, overrun} !== {m_out, m_fv, m_ovr}) begin
          n_fail++;
          $display("FAIL alternating w%0d j%0d: out=%b fv=%b ovr=%b want out=%b fv=%b ovr=%b",
                   w, j, data_out, frame_valid, overrun, m_out, m_fv, m_ovr);
        end
        if (w == 1) begin
          n_tests++;
          if (data_out !== 2'b01 || frame_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL alternating_replay j%0d: out=%b fv=%b want out=01 fv=1",
                     j, data_out, frame_valid);
          end
        end
      end
    end
  endtask

  task automatic test_short_window();
    int lens [5] = '{10, 16, 10, 10, 16};
    bit ones [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int w = 0; w < 5; w++) begin
      for (int j = 0; j < lens[w]; j++) begin
        cyc(j == 0, ones[w]);
        n_tests++;
        if ({data_out, frame_valid, overrun} !== {m_out, m_fv, m_ovr}) begin
          n_fail++;
          $display("FAIL short_window w%0d j%0d: out=%b fv=%b ovr=%b want out=%b fv=%b ovr=%b",
                   w, j, data_out, frame_valid, overrun, m_out, m_fv, m_ovr);
        end
        if (w == 1 || w == 3 || w == 4) begin
          n_tests++;
          if (data_out !== ((j < 10) ? 2'b11 : 2'b00) || frame_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL short_window_replay w%0d j%0d: out=%b fv=%b want out=%b fv=1",
                     w, j, data_out, frame_valid, (j < 10) ? 2'b11 : 2'b00);
          end
        end
      end
    end
  endtask

  task automatic test_long_window();
    int ovr_cnt = 0;
    int fv_cnt  = 0;
    for (int w = 0; w < 2; w++) begin
      for (int j = 0; j < 20; j++) begin
        cyc(j == 0, (w == 0) ? ((j >= 16) ? 1'b1 : bit'($urandom_range(0, 1))) : 1'b0);
        n_tests++;
        if ({data_out, frame_valid, overrun} !== {m_out, m_fv, m_ovr}) begin
          n_fail++;
          $display("FAIL long_window w%0d j%0d: out=%b fv=%b ovr=%b want out=%b fv=%b ovr=%b",
                   w, j, data_out, frame_valid, overrun, m_out, m_fv, m_ovr);
        end
        if (w == 0 && overrun === 1'b1) ovr_cnt++;
        if (w == 1 && frame_valid === 1'b1) fv_cnt++;
        if (w == 1 && j >= 16) begin
          n_tests++;
          if (data_out !== 2'b00) begin
            n_fail++;
            $display("FAIL long_window_tail j%0d: out=%b want 00", j, data_out);
          end
        end
      end
    end
    n_tests++;
    if (ovr_cnt != 4) begin
      n_fail++; $display("FAIL long_window_overrun_count: got %0d want 4", ovr_cnt);
    end
    n_tests++;
    if (fv_cnt != SLOTS) begin
      n_fail++; $display("FAIL long_window_fv_count: got %0d want %0d", fv_cnt, SLOTS);
    end
  endtask

  task automatic test_random();
    for (int w = 0; w < 8; w++) begin
      int len  = $urandom_range(6, 24);
      int hold = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) begin
        cyc(j < hold, bit'($urandom_range(0, 1)));
        n_tests++;
        if ({data_out, frame_valid, overrun} !== {m_out, m_fv, m_ovr}) begin
          n_fail++;
          $display("FAIL random w%0d j%0d: out=%b fv=%b ovr=%b want out=%b fv=%b ovr=%b",
                   w, j, data_out, frame_valid, overrun, m_out, m_fv, m_ovr);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    for (int j = 0; j < 7; j++) cyc(j == 0, 1'b1);
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({data_out, frame_valid, overrun} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_async: out=%b fv=%b ovr=%b want all 0",
               data_out, frame_valid, overrun);
    end
    model_reset();
    grst = 1'b0; data_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    for (int w = 0; w < 2; w++) begin
      for (int j = 0; j < SLOTS; j++) begin
        cyc(j == 0, bit'($urandom_range(0, 1)));
        n_tests++;
        if ({data_out, frame_valid, overrun} !== {m_out, m_fv, m_ovr}) begin
          n_fail++;
          $display("FAIL mid_reset w%0d j%0d: out=%b fv=%b ovr=%b want out=%b fv=%b ovr=%b",
                   w, j, data_out, frame_valid, overrun, m_out, m_fv, m_ovr);
        end
        if (w == 0) begin
          n_tests++;
          if (frame_valid !== 1'b0 || data_out !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_prime j%0d: out=%b fv=%b want out=00 fv=0",
                     j, data_out, frame_valid);
          end
        end
      end
    end
  endtask

  task automatic test_grst_held_at_reset();
    grst = 1'b1; data_in = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 30; j++) begin
      cyc(1'b1, bit'($urandom_range(0, 1)));
      n_tests++;
      if ({data_out, frame_valid, overrun} !== 4'b0000 ||
          {data_out, frame_valid, overrun} !== {m_out, m_fv, m_ovr}) begin
        n_fail++;
        $display("FAIL grst_held j%0d: out=%b fv=%b ovr=%b want all 0",
                 j, data_out, frame_valid, overrun);
      end
    end
    cyc(1'b0, 1'b0);
    for (int w = 0; w < 2; w++) begin
      for (int j = 0; j < SLOTS; j++) begin
        cyc(j == 0, bit'($urandom_range(0, 1)));
        n_tests++;
        if ({data_out, frame_valid, overrun} !== {m_out, m_fv, m_ovr}) begin
          n_fail++;
          $display("FAIL grst_first_edge w%0d j%0d: out=%b fv=%b ovr=%b want out=%b fv=%b ovr=%b",
                   w, j, data_out, frame_valid, overrun, m_out, m_fv, m_ovr);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_spike();
    test_alternating();
    test_short_window();
    test_long_window();
    test_random();
    test_reset_mid_run();
    test_grst_held_at_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
